// File: rtl/bcd_convert_scan_ctrl.sv
// Iterative binary-to-BCD converter (double-dabble, one bit per clock) with a
// free-running 4-digit multiplexed 7-segment scanner.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a new value, waits for valid_i
// S_SHIFT | one add-3/shift iteration per cycle, 12 iterations total
// S_DONE  | new result visible on bcd_o, bcd_valid_o pulses
module bcd_convert_scan_ctrl #(
    parameter int REFRESH_DIV   = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] binario_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic [15:0] bcd_o,
    output logic        bcd_valid_o,
    output logic [3:0]  digit_o,
    output logic [3:0]  anodo_o
);

    localparam int CW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [27:0]    work_q, work_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [15:0]    bcd_q, bcd_d;
    logic [27:0]    work_adj;
    logic [27:0]    work_sh;
    logic [CW-1:0]  refresh_q, refresh_d;
    logic [1:0]     idx_q, idx_d;
    logic           blank;

    // Add-3 correction on each BCD nibble, then the left shift of one iteration
    always_comb begin
        work_adj = work_q;
        for (int i = 0; i < 4; i++) begin
            if (work_q[12 + 4*i +: 4] >= 4'd5) begin
                work_adj[12 + 4*i +: 4] = work_q[12 + 4*i +: 4] + 4'd3;
            end
        end
        work_sh = work_adj << 1;
    end

    // Conversion FSM next-state; bcd is captured on the edge entering S_DONE
    // so the new value is already visible while bcd_valid_o is high
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    work_d  = {16'h0000, binario_i};
                    cnt_d   = 4'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                work_d = work_sh;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd11) begin
                    bcd_d   = work_sh[27:12];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Conversion state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            work_q  <= 28'd0;
            cnt_q   <= 4'd0;
            bcd_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    // Refresh counter and digit index advance, independent of the converter
    always_comb begin
        refresh_d = refresh_q + CW'(1);
        idx_d     = idx_q;
        if (refresh_q == CW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            idx_d     = idx_q + 2'd1;
        end
    end

    // Scanner registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
            idx_q     <= 2'd0;
        end else begin
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
        end
    end

    // Digit/anode decode; a digit is blank when it and all higher digits are zero
    always_comb begin
        digit_o = bcd_q[3:0];
        blank   = 1'b0;
        case (idx_q)
            2'd0: begin
                digit_o = bcd_q[3:0];
                blank   = 1'b0;
            end
            2'd1: begin
                digit_o = bcd_q[7:4];
                blank   = (bcd_q[15:4] == 12'h000);
            end
            2'd2: begin
                digit_o = bcd_q[11:8];
                blank   = (bcd_q[15:8] == 8'h00);
            end
            default: begin
                digit_o = bcd_q[15:12];
                blank   = (bcd_q[15:12] == 4'h0);
            end
        endcase
        if (BLANK_LEADING && blank) begin
            anodo_o = 4'b1111;
        end else begin
            anodo_o = ~(4'b0001 << idx_q);
        end
    end

    assign ready_o     = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign bcd_valid_o = (state_q == S_DONE);
    assign bcd_o       = bcd_q;

endmodule

// File: tb/tb_bcd_convert_scan_ctrl.sv
// Bench for bcd_convert_scan_ctrl: scoreboard of expected BCD results checked
// on every bcd_valid_o pulse, plus per-scenario tasks for timing and scanning.
module tb_bcd_convert_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] binario_i;
    logic        valid_i;
    logic        ready_o, busy_o, bcd_valid_o;
    logic [15:0] bcd_o;
    logic [3:0]  digit_o, anodo_o;

    logic        nb_ready, nb_busy, nb_valid;
    logic [15:0] nb_bcd;
    logic [3:0]  nb_digit, nb_anodo;

    int          checks = 0;
    int          failures = 0;
    int          pulses = 0;
    logic [15:0] sb[$];
    logic [15:0] mon_exp;

    always #5 clk = ~clk;

    bcd_convert_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .binario_i(binario_i), .valid_i(valid_i),
        .ready_o(ready_o), .busy_o(busy_o), .bcd_o(bcd_o),
        .bcd_valid_o(bcd_valid_o), .digit_o(digit_o), .anodo_o(anodo_o)
    );

    bcd_convert_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .binario_i(binario_i), .valid_i(valid_i),
        .ready_o(nb_ready), .busy_o(nb_busy), .bcd_o(nb_bcd),
        .bcd_valid_o(nb_valid), .digit_o(nb_digit), .anodo_o(nb_anodo)
    );

    function automatic logic [15:0] ref_bcd(input int v);
        ref_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Scoreboard monitor: every pulse pops one expected result
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (ready_o === busy_o) begin
                failures++;
                $display("FAIL ready_busy_excl: ready=%b busy=%b", ready_o, busy_o);
            end
            if (bcd_valid_o === 1'b1) begin
                pulses++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: bcd_o=%h with empty scoreboard", bcd_o);
                end else begin
                    mon_exp = sb.pop_front();
                    if (bcd_o !== mon_exp) begin
                        failures++;
                        $display("FAIL sb_bcd: got %h expected %h", bcd_o, mon_exp);
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL wait_ready: ready_o=%b expected 1 within 50 cycles", ready_o);
        end
    endtask

    task automatic convert(input int v);
        int n;
        wait_ready();
        binario_i = 12'(v);
        valid_i   = 1'b1;
        sb.push_back(ref_bcd(v));
        @(negedge clk);
        valid_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL ready_drop: ready_o=%b expected 0", ready_o);
        end
        n = 0;
        while (bcd_valid_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 12) begin
            failures++;
            $display("FAIL latency(%0d): pulse after %0d edges expected 12", v, n);
        end
        checks++;
        if (bcd_o !== ref_bcd(v)) begin
            failures++;
            $display("FAIL convert(%0d): bcd_o=%h expected %h", v, bcd_o, ref_bcd(v));
        end
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || bcd_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL return_idle: ready=%b valid=%b expected 1/0", ready_o, bcd_valid_o);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        valid_i   = 1'b0;
        binario_i = 12'd0;
        #12;
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0 || bcd_o !== 16'h0000 ||
            bcd_valid_o !== 1'b0 || anodo_o !== 4'b1110 || digit_o !== 4'h0) begin
            failures++;
            $display("FAIL reset_values: rdy=%b busy=%b bcd=%h vld=%b an=%b dig=%h expected 1 0 0000 0 1110 0",
                     ready_o, busy_o, bcd_o, bcd_valid_o, anodo_o, digit_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        convert(1234);
        repeat (6) @(negedge clk);
        checks++;
        if (bcd_o !== 16'h1234) begin
            failures++;
            $display("FAIL hold_1234: bcd_o=%h expected 1234", bcd_o);
        end
    endtask

    task automatic test_boundaries();
        convert(0);
        convert(4095);
        convert(999);
    endtask

    task automatic test_hold_valid();
        int n;
        wait_ready();
        binario_i = 12'd55;
        valid_i   = 1'b1;
        sb.push_back(16'h0055);
        @(negedge clk);
        binario_i = 12'd77;
        sb.push_back(16'h0077);
        n = 0;
        while (bcd_valid_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bcd_o !== 16'h0055) begin
            failures++;
            $display("FAIL hold_first: bcd_o=%h expected 0055", bcd_o);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 2) valid_i = 1'b0;
        end while (bcd_valid_o !== 1'b1 && n < 40);
        checks++;
        if (n != 14) begin
            failures++;
            $display("FAIL hold_period: %0d cycles between pulses expected 14", n);
        end
        checks++;
        if (bcd_o !== 16'h0077) begin
            failures++;
            $display("FAIL hold_second: bcd_o=%h expected 0077", bcd_o);
        end
    endtask

    task automatic test_scan();
        int n;
        int k;
        logic [3:0] prev;
        logic [3:0] exp_an, exp_nb, exp_dig;
        convert(7);
        prev = anodo_o;
        @(negedge clk);
        n = 0;
        while (!(prev == 4'b1111 && anodo_o == 4'b1110) && n < 40) begin
            prev = anodo_o;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 40) begin
            failures++;
            $display("FAIL scan_align: anodo_o=%b never went 1111->1110", anodo_o);
        end
        for (int j = 0; j < 20; j++) begin
            k       = (j % 16) / 4;
            exp_an  = (k == 0) ? 4'b1110 : 4'b1111;
            exp_nb  = 4'b1111 ^ (4'b0001 << k);
            exp_dig = (k == 0) ? 4'h7 : 4'h0;
            checks++;
            if (anodo_o !== exp_an || digit_o !== exp_dig) begin
                failures++;
                $display("FAIL scan_blank[%0d]: an=%b dig=%h expected %b %h",
                         j, anodo_o, digit_o, exp_an, exp_dig);
            end
            checks++;
            if (nb_anodo !== exp_nb || nb_digit !== exp_dig) begin
                failures++;
                $display("FAIL scan_noblank[%0d]: an=%b dig=%h expected %b %h",
                         j, nb_anodo, nb_digit, exp_nb, exp_dig);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        int p;
        wait_ready();
        binario_i = 12'd2048;
        valid_i   = 1'b1;
        sb.push_back(16'h2048);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bcd_o !== 16'h0000 || ready_o !== 1'b1 || busy_o !== 1'b0 ||
            anodo_o !== 4'b1110 || bcd_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset: bcd=%h rdy=%b busy=%b an=%b vld=%b expected 0000 1 0 1110 0",
                     bcd_o, ready_o, busy_o, anodo_o, bcd_valid_o);
        end
        void'(sb.pop_back());
        p = pulses;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (pulses != p) begin
            failures++;
            $display("FAIL abort_no_pulse: %0d pulses after abort expected 0", pulses - p);
        end
        convert(2048);
    endtask

    task automatic test_back_to_back();
        int p0;
        int n;
        p0 = pulses;
        valid_i = 1'b1;
        for (int v = 0; v < 4096; v++) begin
            n = 0;
            while (ready_o !== 1'b1 && n < 30) begin
                @(negedge clk);
                n++;
            end
            if (n >= 30) begin
                checks++;
                failures++;
                $display("FAIL sweep_ready: stuck busy at value %0d", v);
            end
            binario_i = 12'(v);
            sb.push_back(ref_bcd(v));
            @(negedge clk);
        end
        valid_i = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (pulses - p0 != 4096 || sb.size() != 0) begin
            failures++;
            $display("FAIL sweep_count: %0d pulses, %0d pending expected 4096 and 0",
                     pulses - p0, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_hold_valid();
        test_scan();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
